// File: rtl/inv_sub_byte.sv
// AES InvSubBytes over a 128-bit state, BYTES_PER_CYCLE inverse S-box lookups per cycle.
// Define INV_SUB_BYTE_CNT_EN to add the blk_cnt output-handshake counter.
module inv_sub_byte #(
  parameter int BYTES_PER_CYCLE = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] block,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] new_block,
  output logic         busy
`ifdef INV_SUB_BYTE_CNT_EN
  ,
  output logic [15:0]  blk_cnt
`endif
);

  // state | meaning
  // IDLE  | waiting for a block, in_ready high
  // BUSY  | substituting one chunk of BYTES_PER_CYCLE bytes per cycle
  // DONE  | new_block holds the result, out_valid high until out_ready

  localparam int N    = 16 / BYTES_PER_CYCLE;
  localparam int CW   = (N > 1) ? $clog2(N) : 1;
  localparam int HW   = 8 * BYTES_PER_CYCLE;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if (!(BYTES_PER_CYCLE inside {1, 2, 4, 8, 16})) begin : g_bad_param
    $error("inv_sub_byte: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
  end

  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    return INV_SBOX[x];
  endfunction

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] chunk;
  logic [127:0]  work, work_shift;
  logic [HW-1:0] head, head_sub;

  // The working copy rotates left one chunk per cycle: the head chunk is always the
  // next unprocessed byte group, and after N rotations the bytes are back in order.
  assign head = work[127 -: HW];

  always_comb begin
    head_sub = '0;
    for (int j = 0; j < BYTES_PER_CYCLE; j++) begin
      head_sub[8*j +: 8] = inv_sbox(head[8*j +: 8]);
    end
  end

  if (BYTES_PER_CYCLE == 16) begin : g_full
    assign work_shift = head_sub;
  end else begin : g_part
    assign work_shift = {work[127-HW:0], head_sub};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      chunk     <= '0;
      work      <= '0;
      new_block <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (in_valid) begin
            work  <= block;
            chunk <= '0;
          end
        end
        BUSY: begin
          work  <= work_shift;
          chunk <= (chunk == LAST) ? '0 : chunk + 1'b1;
          if (chunk == LAST) begin
            new_block <= work_shift;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = BUSY;
      BUSY:    if (chunk == LAST) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign busy      = (state == BUSY);
  assign out_valid = (state == DONE);

`ifdef INV_SUB_BYTE_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      blk_cnt <= '0;
    end else if (state == DONE && out_ready) begin
      blk_cnt <= blk_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_inv_sub_byte.sv
// Bench for inv_sub_byte: one instance per legal BYTES_PER_CYCLE, directed cases plus
// a 256-value sweep, with a queue scoreboard checking forward SubBytes of each result.
module tb_inv_sub_byte;

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] fwd_block(input logic [127:0] b);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[127-8*k -: 8] = SBOX[b[127-8*k -: 8]];
    return r;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  for (genvar g = 0; g < 5; g++) begin : lane
    localparam int BPC = 1 << g;
    localparam int N   = 16 / BPC;

    typedef struct packed {
      logic [127:0] blk;
      int           cyc;
    } sb_t;

    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [127:0] block = '0;
    logic         in_ready, out_valid, busy;
    logic [127:0] new_block;
`ifdef INV_SUB_BYTE_CNT_EN
    logic [15:0]  blk_cnt;
`endif

    sb_t          q[$];
    int           cyc = 0;
    int           outs = 0;
    int           expect_outs = 0;
    int           or_mode = 1;
    bit           done = 1'b0;
    logic         prev_rst = 1'b1;
    logic         prev_ov = 1'b0;
    logic         prev_or = 1'b0;
    logic [127:0] prev_nb = '0;

    inv_sub_byte #(.BYTES_PER_CYCLE(BPC)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .block     (block),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .new_block (new_block),
      .busy      (busy)
`ifdef INV_SUB_BYTE_CNT_EN
      ,
      .blk_cnt   (blk_cnt)
`endif
    );

    // Scoreboard and protocol monitor, sampled mid-cycle.
    always @(negedge clk) begin
      cyc++;
      if (prev_rst) begin
        check("rst_in_ready", 128'(in_ready), 128'd1);
        check("rst_out_valid", 128'(out_valid), 128'd0);
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_new_block", new_block, 128'd0);
`ifdef INV_SUB_BYTE_CNT_EN
        check("rst_blk_cnt", 128'(blk_cnt), 128'd0);
`endif
      end else begin
        if (prev_ov && !prev_or) begin
          check("hold_valid", 128'(out_valid), 128'd1);
          check("hold_data", new_block, prev_nb);
        end
        if (new_block != prev_nb && !(out_valid && !prev_ov))
          check("nb_stable", new_block, prev_nb);
      end
      if (rst_n) begin
        check("onehot", 128'(int'(in_ready) + int'(busy) + int'(out_valid)), 128'd1);
        if (out_valid && !prev_ov) begin
          if (q.size() == 0) check("spurious_out", 128'(out_valid), 128'd0);
          else check("latency", 128'(cyc - q[0].cyc), 128'(N + 1));
        end
        if (out_valid && out_ready) begin
          if (q.size() == 0) check("spurious_hs", 128'(out_valid), 128'd0);
          else begin
            check("fwd_sub", fwd_block(new_block), q[0].blk);
            void'(q.pop_front());
            outs++;
          end
        end
        if (in_valid && in_ready) q.push_back('{blk: block, cyc: cyc});
        prev_ov = out_valid;
      end else begin
        q.delete();
        prev_ov = 1'b0;
      end
      prev_rst = !rst_n;
      prev_or  = out_ready;
      prev_nb  = new_block;
    end

    // out_ready source: 0 = held low, 1 = held high, 2 = random backpressure.
    initial forever begin
      @(posedge clk);
      #2;
      out_ready = (or_mode == 2) ? ($urandom_range(0, 3) != 0) : (or_mode == 1);
    end

    task automatic tick();
      @(posedge clk);
      #1;
    endtask

    task automatic send(input logic [127:0] b);
      int t = 0;
      in_valid = 1'b1;
      block    = b;
      while (!in_ready && t < 300) begin
        tick();
        t++;
      end
      check("send_ready", 128'(in_ready), 128'd1);
      tick();
      in_valid = 1'b0;
      block    = rnd128();
      expect_outs++;
    endtask

    task automatic wait_out();
      int t = 0;
      while (!out_valid && t < 100) begin
        tick();
        t++;
      end
      check("out_wait", 128'(out_valid), 128'd1);
    endtask

    task automatic run_vec(input string tag, input logic [127:0] b, input logic [127:0] e);
      send(b);
      wait_out();
      check(tag, new_block, e);
      tick();
      check("ready_after_out", 128'(in_ready), 128'd1);
    endtask

    initial begin
      logic [127:0] v;
      int t;
      int outs0;
      rst_n   = 1'b0;
      or_mode = 1;
      tick();
      tick();
      rst_n = 1'b1;

      run_vec("r27_zero", {16{8'h63}}, 128'd0);
      run_vec("r28_52", 128'd0, {16{8'h52}});
      run_vec("r28_ff", {16{8'h16}}, {16{8'hff}});
      run_vec("r28_mix", {8'h7c, {15{8'hed}}}, {8'h01, {15{8'h53}}});

      // Long stall in DONE with in_valid/block toggling, then a single handshake.
      or_mode = 0;
      send(rnd128());
      wait_out();
      for (int i = 0; i < 10; i++) begin
        in_valid = i[0];
        block    = rnd128();
        check("r29_in_ready", 128'(in_ready), 128'd0);
        check("r29_out_valid", 128'(out_valid), 128'd1);
        tick();
      end
      in_valid = 1'b0;
      outs0    = outs;
      or_mode  = 1;
      tick();
      or_mode = 0;
      tick();
      tick();
      tick();
      check("r29_one_hs", 128'(outs - outs0), 128'd1);
      check("r29_ov_low", 128'(out_valid), 128'd0);

      // Reset in the second cycle after acceptance aborts the block.
      or_mode = 1;
      send(rnd128());
      tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      expect_outs--;
      for (int i = 0; i < 8; i++) tick();
      check("r30_no_out", 128'(out_valid), 128'd0);

`ifdef INV_SUB_BYTE_CNT_EN
      force dut.blk_cnt = 16'hffff;
      tick();
      release dut.blk_cnt;
      check("cnt_pre", 128'(blk_cnt), 128'hffff);
      send(rnd128());
      wait_out();
      tick();
      check("cnt_wrap", 128'(blk_cnt), 128'd0);
`endif

      or_mode = 2;
      for (int b = 0; b < 16; b++) begin
        for (int k = 0; k < 16; k++) v[127-8*k -: 8] = 8'(16 * b + k);
        send(v);
      end
      for (int r = 0; r < 8; r++) send(rnd128());
      or_mode = 1;
      t = 0;
      while ((q.size() != 0 || !in_ready) && t < 1000) begin
        tick();
        t++;
      end
      check("drain", 128'(q.size()), 128'd0);
      check("outs_count", 128'(outs), 128'(expect_outs));
      done = 1'b1;
    end
  end

  logic all_done;
  assign all_done = lane[0].done & lane[1].done & lane[2].done & lane[3].done & lane[4].done;

  initial begin
    int t = 0;
    while (!all_done && t < 60000) begin
      @(posedge clk);
      t++;
    end
    #2;
    check("all_done", 128'(all_done), 128'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
